// File: rtl/ram_burst_arbiter_if.sv
// Bundle between the two burst requesters, the RAM arbiter and the single-port RAM.
// Handshake: req_i[i] is the valid and is held until done_o[i] (the ready/ack); wr_i/base_i/len_i must be valid with req_i; beat_o[i] acks one wdata_i word and rvalid_o[i] qualifies rdata_o.
interface ram_burst_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic [1:0]          req_i;
  logic [1:0]          wr_i;
  logic [2*ADDR_W-1:0] base_i;
  logic [2*LEN_W-1:0]  len_i;
  logic [2*DATA_W-1:0] wdata_i;
  logic [1:0]          gnt_o;
  logic [1:0]          beat_o;
  logic [DATA_W-1:0]   rdata_o;
  logic [1:0]          rvalid_o;
  logic [1:0]          done_o;
  logic                ram_cs;
  logic                ram_we;
  logic                ram_oe;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  modport slave (
    input  req_i, wr_i, base_i, len_i, wdata_i, ram_rdata,
    output gnt_o, beat_o, rdata_o, rvalid_o, done_o,
    output ram_cs, ram_we, ram_oe, ram_addr, ram_wdata
  );

  modport master (
    output req_i, wr_i, base_i, len_i, wdata_i, ram_rdata,
    input  gnt_o, beat_o, rdata_o, rvalid_o, done_o,
    input  ram_cs, ram_we, ram_oe, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_burst_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two burst requesters;
// sequences contiguous read/write bursts and pulses done on completion.
module ram_burst_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  ram_burst_arbiter_if.slave      bus,
  output logic [1:0]              dbg_state,
  output logic                    dbg_rr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic               rr;
  logic               gsel;
  logic               wr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_q;

  logic               win;
  logic               win_wr;
  logic [ADDR_W-1:0]  win_base;
  logic [LEN_W-1:0]   win_len;

  function automatic logic [1:0] onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  // The round-robin pointer only decides ties; a lone requester always wins.
  always_comb begin
    win      = bus.req_i[rr] ? rr : ~rr;
    win_wr   = bus.wr_i[win];
    win_base = win ? bus.base_i[2*ADDR_W-1:ADDR_W] : bus.base_i[ADDR_W-1:0];
    win_len  = win ? bus.len_i[2*LEN_W-1:LEN_W]    : bus.len_i[LEN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rr           <= 1'b0;
      gsel         <= 1'b0;
      wr_q         <= 1'b0;
      len_q        <= '0;
      beat_q       <= '0;
      bus.gnt_o    <= 2'b00;
      bus.beat_o   <= 2'b00;
      bus.rvalid_o <= 2'b00;
      bus.done_o   <= 2'b00;
      bus.ram_cs   <= 1'b0;
      bus.ram_we   <= 1'b0;
      bus.ram_oe   <= 1'b0;
      bus.ram_addr <= '0;
    end else begin
      bus.done_o   <= 2'b00;
      // A read address presented this cycle returns data next cycle.
      bus.rvalid_o <= (state == S_BURST && !wr_q) ? onehot(gsel) : 2'b00;
      case (state)
        S_IDLE: begin
          if (|bus.req_i) begin
            gsel      <= win;
            wr_q      <= win_wr;
            len_q     <= win_len;
            beat_q    <= '0;
            bus.gnt_o <= onehot(win);
            if (win_len == '0) begin
              state      <= S_DONE;
              bus.done_o <= onehot(win);
            end else begin
              state        <= S_BURST;
              bus.ram_cs   <= 1'b1;
              bus.ram_we   <= win_wr;
              bus.ram_oe   <= ~win_wr;
              bus.ram_addr <= win_base;
              bus.beat_o   <= win_wr ? onehot(win) : 2'b00;
            end
          end
        end
        S_BURST: begin
          if (beat_q == len_q - LEN_W'(1)) begin
            bus.ram_cs   <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_oe   <= 1'b0;
            bus.ram_addr <= '0;
            bus.beat_o   <= 2'b00;
            if (wr_q) begin
              state      <= S_DONE;
              bus.done_o <= onehot(gsel);
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            beat_q       <= beat_q + LEN_W'(1);
            bus.ram_addr <= bus.ram_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          state      <= S_DONE;
          bus.done_o <= onehot(gsel);
        end
        S_DONE: begin
          bus.gnt_o <= 2'b00;
          rr        <= ~gsel;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata_o   = (|bus.rvalid_o) ? bus.ram_rdata : {DATA_W{1'b0}};
  assign bus.ram_wdata = bus.ram_we
                         ? (gsel ? bus.wdata_i[2*DATA_W-1:DATA_W] : bus.wdata_i[DATA_W-1:0])
                         : {DATA_W{1'b0}};
  assign dbg_state     = state;
  assign dbg_rr        = rr;

endmodule

// File: tb/tb_ram_burst_arbiter.sv
// Bench for ram_burst_arbiter: directed and random bursts compared cycle by cycle
// against a transaction-level model of arbitration, burst timing and RAM contents.
module tb_ram_burst_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int W  = 35;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  logic       dbg_rr;

  ram_burst_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  ram_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_rr    (dbg_rr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] ram_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] wbuf [2][256];
  logic [7:0] wq0[$];
  logic [7:0] wq1[$];
  logic       rr_m = 1'b0;

  // Synchronous RAM fixture: one-cycle read latency; reloaded from the model while in reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= ref_mem[i];
    end else begin
      if (bus.ram_cs && bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_cs && bus.ram_oe && !bus.ram_we) bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] snap(input logic [1:0] gnt, input logic [1:0] beat,
                                        input logic [1:0] rv, input logic [1:0] dn,
                                        input logic cs, input logic we, input logic oe,
                                        input logic [7:0] addr, input logic [7:0] rdata,
                                        input logic [7:0] wdata);
    return {gnt, beat, rv, dn, cs, we, oe, addr, rdata, wdata};
  endfunction

  function automatic logic [1:0] oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  // Expected per-cycle view of one burst, from grant cycle through the done cycle.
  function automatic void append_burst(input logic p, input logic wr,
                                       input logic [7:0] base, input logic [7:0] len);
    logic [7:0] a;
    logic [7:0] ap;
    if (wr) begin
      for (int t = 0; t < int'(len); t++) begin
        a = base + 8'(t);
        exp_q.push_back(snap(oh(p), oh(p), 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, a, 8'h00, wbuf[p][t]));
        ref_mem[a] = wbuf[p][t];
      end
    end else if (len != 8'd0) begin
      for (int t = 0; t < int'(len); t++) begin
        a  = base + 8'(t);
        ap = a - 8'd1;
        exp_q.push_back(snap(oh(p), 2'b00, (t > 0) ? oh(p) : 2'b00, 2'b00, 1'b1, 1'b0, 1'b1,
                             a, (t > 0) ? ref_mem[ap] : 8'h00, 8'h00));
      end
      ap = base + len - 8'd1;
      exp_q.push_back(snap(oh(p), 2'b00, oh(p), 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, ref_mem[ap], 8'h00));
    end
    exp_q.push_back(snap(oh(p), 2'b00, 2'b00, oh(p), 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_wdata();
    bus.wdata_i = {(wq1.size() > 0) ? wq1[0] : 8'h00, (wq0.size() > 0) ? wq0[0] : 8'h00};
  endtask

  // Compares n cycles at the falling edge; the requester side then acts on the
  // expected beat/done strobes just after the next rising edge.
  task automatic check_cycles(input int n, input string tag);
    logic [W-1:0] e;
    logic [W-1:0] o;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = {bus.gnt_o, bus.beat_o, bus.rvalid_o, bus.done_o, bus.ram_cs, bus.ram_we,
           bus.ram_oe, bus.ram_addr, bus.rdata_o, bus.ram_wdata};
      if (e[30:29] == 2'b00) o[15:8] = 8'h00;
      if (!e[25])            o[7:0]  = 8'h00;
      if (!e[26])            o[23:16] = 8'h00;
      check(tag, 64'(o), 64'(e));
      @(posedge clk);
      #1;
      bus.req_i = bus.req_i & ~e[28:27];
      if (e[31] && wq0.size() > 0) void'(wq0.pop_front());
      if (e[32] && wq1.size() > 0) void'(wq1.pop_front());
      drive_wdata();
    end
  endtask

  // Called just after a rising edge with the DUT idle; seed != 0 gives seed+t write data.
  task automatic issue(input logic [1:0] mask, input logic [1:0] wr,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] l0, input logic [7:0] l1,
                       input logic [7:0] seed, input string tag);
    logic first;
    logic second;
    for (int p = 0; p < 2; p++) begin
      if (mask[p] && wr[p]) begin
        for (int t = 0; t < int'(p ? l1 : l0); t++) begin
          wbuf[p][t] = (seed != 8'h00) ? seed + 8'(t) : 8'($urandom_range(0, 255));
          if (p == 0) wq0.push_back(wbuf[p][t]);
          else        wq1.push_back(wbuf[p][t]);
        end
      end
    end
    bus.wr_i   = wr;
    bus.base_i = {b1, b0};
    bus.len_i  = {l1, l0};
    bus.req_i  = mask;
    drive_wdata();
    exp_q.push_back('0);
    first = (mask == 2'b11) ? rr_m : mask[1];
    append_burst(first, wr[first], first ? b1 : b0, first ? l1 : l0);
    rr_m = ~first;
    if (mask == 2'b11) begin
      second = ~first;
      exp_q.push_back('0);
      append_burst(second, wr[second], second ? b1 : b0, second ? l1 : l0);
      rr_m = ~second;
    end
    exp_q.push_back('0);
    exp_q.push_back('0);
    check_cycles(exp_q.size(), tag);
  endtask

  task automatic reset_mid_burst();
    bus.wr_i   = 2'b01;
    bus.base_i = {8'h00, 8'h80};
    bus.len_i  = {8'h00, 8'd8};
    bus.req_i  = 2'b01;
    for (int t = 0; t < 8; t++) begin
      wbuf[0][t] = 8'($urandom_range(0, 255));
      wq0.push_back(wbuf[0][t]);
    end
    drive_wdata();
    exp_q.push_back('0);
    for (int t = 0; t < 3; t++)
      exp_q.push_back(snap(2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 8'h80 + 8'(t), 8'h00, wbuf[0][t]));
    check_cycles(3, "rst_pre");
    for (int t = 0; t < 3; t++) ref_mem[8'h80 + 8'(t)] = wbuf[0][t];
    rst = 1'b1;
    check_cycles(1, "rst_beat2");
    rst       = 1'b0;
    bus.req_i = 2'b00;
    wq0.delete();
    drive_wdata();
    rr_m = 1'b0;
    repeat (4) exp_q.push_back('0);
    check_cycles(4, "rst_after");
    check("rst_rr", 64'(dbg_rr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_rdata", 64'(bus.rdata_o), 64'd0);
    check("rst_wdata", 64'(bus.ram_wdata), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] m;
    logic [1:0] w;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    bus.req_i   = 2'b00;
    bus.wr_i    = 2'b00;
    bus.base_i  = '0;
    bus.len_i   = '0;
    bus.wdata_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", 64'({bus.gnt_o, bus.beat_o, bus.rvalid_o, bus.done_o, bus.ram_cs,
                            bus.ram_we, bus.ram_oe, bus.ram_addr, bus.rdata_o, bus.ram_wdata}), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    check("reset_rr", 64'(dbg_rr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(2'b01, 2'b01, 8'h10, 8'h00, 8'd4, 8'd0, 8'h0A, "wr_p0_basic");
    issue(2'b10, 2'b00, 8'h00, 8'h10, 8'd0, 8'd4, 8'h00, "rd_p1_basic");
    issue(2'b11, 2'b01, 8'h20, 8'h10, 8'd3, 8'd2, 8'h00, "both_a");
    issue(2'b11, 2'b10, 8'h10, 8'h30, 8'd5, 8'd3, 8'h00, "both_b");
    issue(2'b11, 2'b11, 8'h40, 8'h50, 8'd1, 8'd2, 8'h00, "both_c");
    issue(2'b01, 2'b01, 8'hFE, 8'h00, 8'd3, 8'd0, 8'h00, "wr_wrap");
    issue(2'b10, 2'b00, 8'h00, 8'hFE, 8'd0, 8'd3, 8'h00, "rd_wrap");
    issue(2'b01, 2'b01, 8'h33, 8'h00, 8'd0, 8'd0, 8'h00, "len0_wr");
    issue(2'b10, 2'b00, 8'h00, 8'h44, 8'd0, 8'd0, 8'h00, "len0_rd");
    issue(2'b01, 2'b00, 8'hFF, 8'h00, 8'd1, 8'd0, 8'h00, "rd_len1");

    for (int k = 0; k < 24; k++) begin
      m = 2'($urandom_range(1, 3));
      w = 2'($urandom_range(0, 3));
      issue(m, w, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 10)), 8'($urandom_range(0, 10)), 8'h00, "random");
    end

    if (rr_m == 1'b0) issue(2'b01, 2'b01, 8'h60, 8'h00, 8'd2, 8'd0, 8'h00, "pre_rst");
    reset_mid_burst();
    issue(2'b11, 2'b00, 8'h80, 8'h7E, 8'd4, 8'd4, 8'h00, "post_rst_both");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
